// File: rtl/sat_pkg.sv
// Shared definitions for the WalkSAT clause tracking datapath: default sizing
// and the tracker FSM state encoding.
package sat_pkg;

   localparam int DEF_NUM_CLAUSES      = 20;
   localparam int DEF_NUM_CLAUSES_BITS = 5;
   localparam int DEF_LIT_COUNT_BITS   = 2;
   localparam int DEF_CHUNK            = 4;
   localparam int NUM_CHUNKS           = DEF_NUM_CLAUSES / DEF_CHUNK;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/clause_count_update.sv
// Next true-literal count for one clause given the flipped variable's make/break
// contribution; saturates at both ends and flags the over/underflow.
module clause_count_update #(
   parameter int LIT_COUNT_BITS = 2
) (
   input  logic [LIT_COUNT_BITS-1:0] count_i,
   input  logic                      make_i,
   input  logic                      break_i,
   output logic [LIT_COUNT_BITS-1:0] count_o,
   output logic                      err_o
);

   localparam logic [LIT_COUNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [LIT_COUNT_BITS-1:0] CNT_ONE = LIT_COUNT_BITS'(1);

   always_comb begin
      count_o = count_i;
      err_o   = 1'b0;
      // make and break together cancel out, so only the exclusive cases move the count
      if (make_i && !break_i) begin
         if (count_i == CNT_MAX) begin
            err_o = 1'b1;
         end else begin
            count_o = count_i + CNT_ONE;
         end
      end else if (break_i && !make_i) begin
         if (count_i == '0) begin
            err_o = 1'b1;
         end else begin
            count_o = count_i - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/clause_status_tracker.sv
// Per-clause true-literal counts with broken (count==1) and unsat (count==0) status
// vectors. Define UNSAT_COUNT_EN to add the num_unsat_o popcount output.
module clause_status_tracker
   import sat_pkg::*;
#(
   parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
   parameter int NUM_CLAUSES_BITS = DEF_NUM_CLAUSES_BITS,
   parameter int LIT_COUNT_BITS   = DEF_LIT_COUNT_BITS,
   parameter int CHUNK            = DEF_CHUNK
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flip_valid_i,
   output logic                        flip_ready_o,
   input  logic [NUM_CLAUSES-1:0]      make_mask_i,
   input  logic [NUM_CLAUSES-1:0]      break_mask_i,
   input  logic                        load_en_i,
   input  logic [NUM_CLAUSES_BITS-1:0] load_idx_i,
   input  logic [LIT_COUNT_BITS-1:0]   load_count_i,
   output logic [NUM_CLAUSES-1:0]      clause_broken_o,
   output logic [NUM_CLAUSES-1:0]      clause_unsat_o,
   output logic                        status_valid_o,
`ifdef UNSAT_COUNT_EN
   output logic [NUM_CLAUSES_BITS-1:0] num_unsat_o,
`endif
   output logic                        error_o
);

   localparam int CHUNKS_N = NUM_CLAUSES / CHUNK;
   localparam int PTR_W    = (CHUNKS_N > 1) ? $clog2(CHUNKS_N) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CHUNKS_N - 1);

   typedef logic [LIT_COUNT_BITS-1:0] cnt_t;

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [NUM_CLAUSES-1:0] make_q, make_d;
   logic [NUM_CLAUSES-1:0] break_q, break_d;
   cnt_t                   count_q [NUM_CLAUSES];
   cnt_t                   count_d [NUM_CLAUSES];
   logic [NUM_CLAUSES-1:0] broken_q, broken_d;
   logic [NUM_CLAUSES-1:0] unsat_q, unsat_d;
   logic                   status_valid_q, status_valid_d;
   logic                   error_q, error_d;

   cnt_t                   sel_cnt [CHUNK];
   cnt_t                   upd_cnt [CHUNK];
   logic [CHUNK-1:0]       sel_make;
   logic [CHUNK-1:0]       sel_break;
   logic [CHUNK-1:0]       upd_err;

   logic                   flip_acc;
   logic                   load_hit;
   logic                   out_upd;

   assign flip_ready_o = (state_q == ST_IDLE);
   assign flip_acc     = flip_valid_i && (state_q == ST_IDLE);
   // A flip accepted in the same cycle takes priority, so the load is dropped
   assign load_hit     = load_en_i && (state_q == ST_IDLE) && !flip_valid_i &&
                         (load_idx_i < NUM_CLAUSES_BITS'(NUM_CLAUSES));
   assign out_upd      = (state_q == ST_DONE) || load_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      status_valid_d = status_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (flip_acc) begin
               state_d        = ST_UPDATE;
               ptr_d          = '0;
               status_valid_d = 1'b0;
            end else begin
               status_valid_d = !load_hit;
            end
         end
         ST_UPDATE: begin
            status_valid_d = 1'b0;
            ptr_d          = ptr_q + PTR_W'(1);
            if (ptr_q == LAST_PTR) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            status_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      for (int j = 0; j < CHUNK; j++) begin
         sel_cnt[j]   = '0;
         sel_make[j]  = 1'b0;
         sel_break[j] = 1'b0;
         for (int c = 0; c < CHUNKS_N; c++) begin
            if (ptr_q == PTR_W'(c)) begin
               sel_cnt[j]   = count_q[c*CHUNK + j];
               sel_make[j]  = make_q[c*CHUNK + j];
               sel_break[j] = break_q[c*CHUNK + j];
            end
         end
      end
   end

   for (genvar g = 0; g < CHUNK; g++) begin : g_upd
      clause_count_update #(
         .LIT_COUNT_BITS (LIT_COUNT_BITS)
      ) u_upd (
         .count_i (sel_cnt[g]),
         .make_i  (sel_make[g]),
         .break_i (sel_break[g]),
         .count_o (upd_cnt[g]),
         .err_o   (upd_err[g])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_CLAUSES; i++) begin
         count_d[i] = count_q[i];
         if ((state_q == ST_UPDATE) && (ptr_q == PTR_W'(i / CHUNK))) begin
            count_d[i] = upd_cnt[i % CHUNK];
         end else if (load_hit && (load_idx_i == NUM_CLAUSES_BITS'(i))) begin
            count_d[i] = load_count_i;
         end
      end
   end

   // Status vectors stay frozen through UPDATE and are only refreshed on DONE or a load
   always_comb begin
      broken_d = broken_q;
      unsat_d  = unsat_q;
      if (out_upd) begin
         for (int i = 0; i < NUM_CLAUSES; i++) begin
            broken_d[i] = (count_d[i] == cnt_t'(1));
            unsat_d[i]  = (count_d[i] == '0);
         end
      end
   end

   always_comb begin
      make_d  = flip_acc ? make_mask_i  : make_q;
      break_d = flip_acc ? break_mask_i : break_q;
      error_d = error_q || ((state_q == ST_UPDATE) && (|upd_err));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q          <= '0;
         make_q         <= '0;
         break_q        <= '0;
         count_q        <= '{default: '0};
         broken_q       <= '0;
         unsat_q        <= '1;
         status_valid_q <= 1'b1;
         error_q        <= 1'b0;
      end else begin
         ptr_q          <= ptr_d;
         make_q         <= make_d;
         break_q        <= break_d;
         count_q        <= count_d;
         broken_q       <= broken_d;
         unsat_q        <= unsat_d;
         status_valid_q <= status_valid_d;
         error_q        <= error_d;
      end
   end

`ifdef UNSAT_COUNT_EN
   logic [NUM_CLAUSES_BITS-1:0] num_unsat_q, num_unsat_d;

   always_comb begin
      num_unsat_d = num_unsat_q;
      if (out_upd) begin
         num_unsat_d = '0;
         for (int i = 0; i < NUM_CLAUSES; i++) begin
            num_unsat_d = num_unsat_d + NUM_CLAUSES_BITS'(unsat_d[i]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_unsat_q <= NUM_CLAUSES_BITS'(NUM_CLAUSES);
      end else begin
         num_unsat_q <= num_unsat_d;
      end
   end

   assign num_unsat_o = num_unsat_q;
`endif

   assign clause_broken_o = broken_q;
   assign clause_unsat_o  = unsat_q;
   assign status_valid_o  = status_valid_q;
   assign error_o         = error_q;

endmodule

// File: tb/tb_clause_status_tracker.sv
// Directed bench for clause_status_tracker; also covers num_unsat_o when
// UNSAT_COUNT_EN is defined.
module tb_clause_status_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        flip_valid_i;
   logic        flip_ready_o;
   logic [19:0] make_mask_i;
   logic [19:0] break_mask_i;
   logic        load_en_i;
   logic [4:0]  load_idx_i;
   logic [1:0]  load_count_i;
   logic [19:0] clause_broken_o;
   logic [19:0] clause_unsat_o;
   logic        status_valid_o;
   logic        error_o;
`ifdef UNSAT_COUNT_EN
   logic [4:0]  num_unsat_o;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int lat;
   bit held;

   always #5 clk = ~clk;

   clause_status_tracker dut (
      .clk             (clk),
      .reset           (reset),
      .flip_valid_i    (flip_valid_i),
      .flip_ready_o    (flip_ready_o),
      .make_mask_i     (make_mask_i),
      .break_mask_i    (break_mask_i),
      .load_en_i       (load_en_i),
      .load_idx_i      (load_idx_i),
      .load_count_i    (load_count_i),
      .clause_broken_o (clause_broken_o),
      .clause_unsat_o  (clause_unsat_o),
      .status_valid_o  (status_valid_o),
`ifdef UNSAT_COUNT_EN
      .num_unsat_o     (num_unsat_o),
`endif
      .error_o         (error_o)
   );

   // Stimulus only: presents one flip, then waits (bounded) for status_valid_o.
   // lat counts edges from the accepting edge; held reports frozen outputs and ready low meanwhile.
   task automatic apply_flip(input logic [19:0] mk, input logic [19:0] bk,
                             output int lt, output bit hd);
      logic [19:0] pre_b, pre_u;
      pre_b = clause_broken_o;
      pre_u = clause_unsat_o;
      flip_valid_i = 1'b1;
      make_mask_i  = mk;
      break_mask_i = bk;
      @(posedge clk); #1;
      flip_valid_i = 1'b0;
      make_mask_i  = '0;
      break_mask_i = '0;
      lt = 1;
      hd = 1'b1;
      while (status_valid_o !== 1'b1 && lt < 30) begin
         if (clause_broken_o !== pre_b || clause_unsat_o !== pre_u || flip_ready_o !== 1'b0) hd = 1'b0;
         @(posedge clk); #1;
         lt++;
      end
   endtask

   task automatic do_load(input logic [4:0] idx, input logic [1:0] cnt);
      load_en_i    = 1'b1;
      load_idx_i   = idx;
      load_count_i = cnt;
      @(posedge clk); #1;
      load_en_i    = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      flip_valid_i = 1'b0; make_mask_i = '0; break_mask_i = '0;
      load_en_i = 1'b0; load_idx_i = '0; load_count_i = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (clause_broken_o !== 20'h00000) begin n_fail++; $display("FAIL reset_broken: got %h want %h", clause_broken_o, 20'h00000); end
      n_chk++; if (clause_unsat_o !== 20'hFFFFF) begin n_fail++; $display("FAIL reset_unsat: got %h want %h", clause_unsat_o, 20'hFFFFF); end
      n_chk++; if (status_valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_status_valid: got %b want 1", status_valid_o); end
      n_chk++; if (flip_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", flip_ready_o); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd20) begin n_fail++; $display("FAIL reset_num_unsat: got %0d want 20", num_unsat_o); end
`endif
   endtask

   task automatic test_load;
      do_load(5'd0, 2'd1);
      n_chk++; if (clause_unsat_o !== 20'hFFFFE) begin n_fail++; $display("FAIL load0_unsat: got %h want %h", clause_unsat_o, 20'hFFFFE); end
      n_chk++; if (clause_broken_o !== 20'h00001) begin n_fail++; $display("FAIL load0_broken: got %h want %h", clause_broken_o, 20'h00001); end
      n_chk++; if (status_valid_o !== 1'b0) begin n_fail++; $display("FAIL load0_status_valid: got %b want 0", status_valid_o); end
      for (int i = 1; i < 20; i++) do_load(5'(i), 2'd1);
      @(posedge clk); #1;
      n_chk++; if (status_valid_o !== 1'b1) begin n_fail++; $display("FAIL load_all_status_valid: got %b want 1", status_valid_o); end
      n_chk++; if (clause_unsat_o !== 20'h00000) begin n_fail++; $display("FAIL load_all_unsat: got %h want %h", clause_unsat_o, 20'h00000); end
      n_chk++; if (clause_broken_o !== 20'hFFFFF) begin n_fail++; $display("FAIL load_all_broken: got %h want %h", clause_broken_o, 20'hFFFFF); end
      do_load(5'd20, 2'd0);
      n_chk++; if (clause_unsat_o !== 20'h00000) begin n_fail++; $display("FAIL load_bad_idx_unsat: got %h want %h", clause_unsat_o, 20'h00000); end
      n_chk++; if (status_valid_o !== 1'b1) begin n_fail++; $display("FAIL load_bad_idx_status_valid: got %b want 1", status_valid_o); end
   endtask

   task automatic test_flip_break;
      n_chk++; if (flip_ready_o !== 1'b1) begin n_fail++; $display("FAIL flip_break_ready_pre: got %b want 1", flip_ready_o); end
      apply_flip(20'h00000, 20'h0000F, lat, held);
      n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL flip_break_latency: got %0d want 7", lat); end
      n_chk++; if (held !== 1'b1) begin n_fail++; $display("FAIL flip_break_frozen: got %b want 1", held); end
      n_chk++; if (clause_unsat_o !== 20'h0000F) begin n_fail++; $display("FAIL flip_break_unsat: got %h want %h", clause_unsat_o, 20'h0000F); end
      n_chk++; if (clause_broken_o !== 20'hFFFF0) begin n_fail++; $display("FAIL flip_break_broken: got %h want %h", clause_broken_o, 20'hFFFF0); end
      n_chk++; if (flip_ready_o !== 1'b1) begin n_fail++; $display("FAIL flip_break_ready_post: got %b want 1", flip_ready_o); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL flip_break_error: got %b want 0", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd4) begin n_fail++; $display("FAIL flip_break_num_unsat: got %0d want 4", num_unsat_o); end
`endif
   endtask

   task automatic test_make_break_cancel;
      do_load(5'd0, 2'd2);
      do_load(5'd1, 2'd2);
      @(posedge clk); #1;
      n_chk++; if (clause_unsat_o !== 20'h0000C) begin n_fail++; $display("FAIL cancel_pre_unsat: got %h want %h", clause_unsat_o, 20'h0000C); end
      apply_flip(20'h00003, 20'h00003, lat, held);
      n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL cancel_latency: got %0d want 7", lat); end
      n_chk++; if (clause_unsat_o !== 20'h0000C) begin n_fail++; $display("FAIL cancel_unsat: got %h want %h", clause_unsat_o, 20'h0000C); end
      n_chk++; if (clause_broken_o !== 20'hFFFF0) begin n_fail++; $display("FAIL cancel_broken: got %h want %h", clause_broken_o, 20'hFFFF0); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL cancel_error: got %b want 0", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd2) begin n_fail++; $display("FAIL cancel_num_unsat: got %0d want 2", num_unsat_o); end
`endif
      apply_flip(20'h00004, 20'h00000, lat, held);
      n_chk++; if (clause_unsat_o !== 20'h00008) begin n_fail++; $display("FAIL make_unsat: got %h want %h", clause_unsat_o, 20'h00008); end
      n_chk++; if (clause_broken_o !== 20'hFFFF4) begin n_fail++; $display("FAIL make_broken: got %h want %h", clause_broken_o, 20'hFFFF4); end
   endtask

   task automatic test_underflow;
      apply_flip(20'h00000, 20'h00008, lat, held);
      n_chk++; if (clause_unsat_o !== 20'h00008) begin n_fail++; $display("FAIL udf_unsat: got %h want %h", clause_unsat_o, 20'h00008); end
      n_chk++; if (clause_broken_o !== 20'hFFFF4) begin n_fail++; $display("FAIL udf_broken: got %h want %h", clause_broken_o, 20'hFFFF4); end
      n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL udf_error: got %b want 1", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd1) begin n_fail++; $display("FAIL udf_num_unsat: got %0d want 1", num_unsat_o); end
`endif
      apply_flip(20'h00008, 20'h00000, lat, held);
      n_chk++; if (clause_unsat_o !== 20'h00000) begin n_fail++; $display("FAIL udf_after_unsat: got %h want %h", clause_unsat_o, 20'h00000); end
      n_chk++; if (clause_broken_o !== 20'hFFFFC) begin n_fail++; $display("FAIL udf_after_broken: got %h want %h", clause_broken_o, 20'hFFFFC); end
      n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL udf_sticky_error: got %b want 1", error_o); end
   endtask

   task automatic test_back_to_back;
      flip_valid_i = 1'b1; make_mask_i = 20'h00000; break_mask_i = 20'h00010;
      @(posedge clk); #1;
      // Second request and a load are held during the whole update
      flip_valid_i = 1'b1; make_mask_i = 20'h00010; break_mask_i = 20'h00000;
      load_en_i = 1'b1; load_idx_i = 5'd6; load_count_i = 2'd0;
      repeat (5) @(posedge clk);
      #1;
      n_chk++; if (flip_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy: got %b want 0", flip_ready_o); end
      n_chk++; if (status_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_status_busy: got %b want 0", status_valid_o); end
      n_chk++; if (clause_broken_o !== 20'hFFFFC) begin n_fail++; $display("FAIL b2b_frozen_broken: got %h want %h", clause_broken_o, 20'hFFFFC); end
      @(posedge clk); #1;
      n_chk++; if (flip_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b want 1", flip_ready_o); end
      n_chk++; if (status_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_status_first: got %b want 1", status_valid_o); end
      n_chk++; if (clause_unsat_o !== 20'h00010) begin n_fail++; $display("FAIL b2b_first_unsat: got %h want %h", clause_unsat_o, 20'h00010); end
      n_chk++; if (clause_broken_o !== 20'hFFFEC) begin n_fail++; $display("FAIL b2b_first_broken: got %h want %h", clause_broken_o, 20'hFFFEC); end
      @(posedge clk); #1;
      flip_valid_i = 1'b0; make_mask_i = '0; load_en_i = 1'b0;
      n_chk++; if (flip_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got %b want 0", flip_ready_o); end
      repeat (6) @(posedge clk);
      #1;
      n_chk++; if (status_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_status_second: got %b want 1", status_valid_o); end
      n_chk++; if (clause_unsat_o !== 20'h00000) begin n_fail++; $display("FAIL b2b_second_unsat: got %h want %h", clause_unsat_o, 20'h00000); end
      n_chk++; if (clause_broken_o !== 20'hFFFFC) begin n_fail++; $display("FAIL b2b_load_ignored: got %h want %h", clause_broken_o, 20'hFFFFC); end
      n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL b2b_error_sticky: got %b want 1", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd0) begin n_fail++; $display("FAIL b2b_num_unsat: got %0d want 0", num_unsat_o); end
`endif
   endtask

   task automatic test_reset_mid_update;
      flip_valid_i = 1'b1; make_mask_i = 20'h00000; break_mask_i = 20'h00F00;
      @(posedge clk); #1;
      flip_valid_i = 1'b0; break_mask_i = '0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      n_chk++; if (status_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_status: got %b want 1", status_valid_o); end
      n_chk++; if (flip_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", flip_ready_o); end
      n_chk++; if (clause_unsat_o !== 20'hFFFFF) begin n_fail++; $display("FAIL mid_reset_unsat: got %h want %h", clause_unsat_o, 20'hFFFFF); end
      n_chk++; if (clause_broken_o !== 20'h00000) begin n_fail++; $display("FAIL mid_reset_broken: got %h want %h", clause_broken_o, 20'h00000); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_error: got %b want 0", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd20) begin n_fail++; $display("FAIL mid_reset_num_unsat: got %0d want 20", num_unsat_o); end
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (clause_unsat_o !== 20'hFFFFF) begin n_fail++; $display("FAIL mid_reset_discard: got %h want %h", clause_unsat_o, 20'hFFFFF); end
      n_chk++; if (flip_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready_after: got %b want 1", flip_ready_o); end
   endtask

   task automatic test_overflow;
      do_load(5'd5, 2'd3);
      @(posedge clk); #1;
      n_chk++; if (clause_unsat_o !== 20'hFFFDF) begin n_fail++; $display("FAIL ovf_pre_unsat: got %h want %h", clause_unsat_o, 20'hFFFDF); end
      apply_flip(20'h00020, 20'h00000, lat, held);
      n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL ovf_latency: got %0d want 7", lat); end
      n_chk++; if (clause_unsat_o !== 20'hFFFDF) begin n_fail++; $display("FAIL ovf_unsat: got %h want %h", clause_unsat_o, 20'hFFFDF); end
      n_chk++; if (clause_broken_o !== 20'h00000) begin n_fail++; $display("FAIL ovf_broken: got %h want %h", clause_broken_o, 20'h00000); end
      n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b want 1", error_o); end
`ifdef UNSAT_COUNT_EN
      n_chk++; if (num_unsat_o !== 5'd19) begin n_fail++; $display("FAIL ovf_num_unsat: got %0d want 19", num_unsat_o); end
`endif
   endtask

   initial begin
      test_reset();
      test_load();
      test_flip_break();
      test_make_break_cancel();
      test_underflow();
      test_back_to_back();
      test_reset_mid_update();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
